// File: rtl/output_byte_sink.sv
// output_byte_sink: buffers the fetch-stage byte stream in a FIFO and hands it to the host over valid/ready.
// Optional feature macro: OUTPUT_SINK_CHECKSUM_EN appends a modulo-256 checksum byte to each frame.
module output_byte_sink #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_done,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] byte_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_FINISH = 3'd3
`ifdef OUTPUT_SINK_CHECKSUM_EN
    ,
    ST_CKSUM  = 3'd4
`endif
  } state_e;

  logic [7:0]       mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  state_e           state_q;
  logic             in_done_q;
  logic             overflow_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] byte_count_q;
`ifdef OUTPUT_SINK_CHECKSUM_EN
  logic [7:0]       cksum_q;
`endif

  logic [AW:0] fill_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        fifo_pop_s;
  logic        push_req_s;
  logic        push_ok_s;
  logic        done_rise_s;
  logic        last_entry_s;

  assign fill_s       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_pop_s   = !fifo_empty_s && out_ready;
  assign push_req_s   = in_valid && ((state_q == ST_IDLE) || (state_q == ST_STREAM));
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok_s    = push_req_s && (!fifo_full_s || fifo_pop_s);
  assign done_rise_s  = in_done && !in_done_q;
  assign last_entry_s = (fill_s == PTR_ONE);

  // FIFO storage; contents are never observed while empty, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_ok_s && !clear) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  // Frame FSM, FIFO pointers, counters and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ST_IDLE;
      in_done_q    <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      byte_count_q <= '0;
`ifdef OUTPUT_SINK_CHECKSUM_EN
      cksum_q      <= 8'h00;
`endif
    end else if (clear) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= ST_IDLE;
      in_done_q    <= in_done;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      byte_count_q <= '0;
`ifdef OUTPUT_SINK_CHECKSUM_EN
      cksum_q      <= 8'h00;
`endif
    end else begin
      in_done_q    <= in_done;
      frame_done_q <= 1'b0;
      if (fifo_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q      <= ST_STREAM;
            busy_q       <= 1'b1;
            overflow_q   <= 1'b0;
            byte_count_q <= CNT_ONE;
`ifdef OUTPUT_SINK_CHECKSUM_EN
            cksum_q      <= in_data;
`endif
          end
        end
        ST_STREAM: begin
          if (in_valid) begin
            if (push_ok_s) begin
              if (byte_count_q != {CNT_W{1'b1}}) begin
                byte_count_q <= byte_count_q + CNT_ONE;
              end
`ifdef OUTPUT_SINK_CHECKSUM_EN
              cksum_q <= cksum_q + in_data;
`endif
            end else begin
              overflow_q <= 1'b1;
            end
          end
          if (done_rise_s) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (in_valid) begin
            overflow_q <= 1'b1;
          end
`ifdef OUTPUT_SINK_CHECKSUM_EN
          if (fifo_empty_s) begin
            state_q <= ST_CKSUM;
          end
`else
          // An already-empty FIFO (host drained it during STREAM) must still close the frame.
          if (fifo_empty_s || (fifo_pop_s && last_entry_s)) begin
            state_q      <= ST_FINISH;
            frame_done_q <= 1'b1;
          end
`endif
        end
`ifdef OUTPUT_SINK_CHECKSUM_EN
        ST_CKSUM: begin
          if (in_valid) begin
            overflow_q <= 1'b1;
          end
          if (out_ready) begin
            state_q      <= ST_FINISH;
            frame_done_q <= 1'b1;
          end
        end
`endif
        ST_FINISH: begin
          if (in_valid) begin
            overflow_q <= 1'b1;
          end
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Host-facing byte view, derived only from registered state.
  always_comb begin
    out_valid = !fifo_empty_s;
    out_data  = fifo_empty_s ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
`ifdef OUTPUT_SINK_CHECKSUM_EN
    out_last  = 1'b0;
    if (state_q == ST_CKSUM) begin
      out_valid = 1'b1;
      out_data  = cksum_q;
      out_last  = 1'b1;
    end else begin
      out_last  = 1'b0;
    end
`else
    out_last  = (state_q == ST_DRAIN) && last_entry_s;
`endif
  end

  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign byte_count = byte_count_q;

endmodule

// File: doc/output_byte_sink.md
# output_byte_sink

Downstream stage of the output fetch pipeline. Accepts the one-byte-per-cycle stream that the memory fetch stage produces from packed 128-bit words, buffers it in a small FIFO, and presents it to the external host port over a valid/ready handshake. The fetch stage cannot be stalled, so this block absorbs host backpressure and flags overflow. It frames each transfer with a last-byte marker and a completion pulse.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in bytes; power of two, ≥4
- CNT_W, 24, width of the byte counter

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush; highest priority after reset
- in_valid  in  1  byte present on in_data this cycle (fetch StartOut)
- in_data  in  8  byte from fetch stage (DataOut)
- in_done  in  1  fetch-complete level; rising edge ends the frame
- out_valid  out  1  out_data holds a valid byte
- out_data  out  8  byte to host
- out_last  out  1  qualifies the final byte of the frame
- out_ready  in  1  host accepts when out_valid & out_ready
- overflow  out  1  sticky: at least one input byte was dropped
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last byte is accepted
- byte_count  out  CNT_W  bytes accepted into the FIFO this frame

## Operation
- States: IDLE, STREAM, DRAIN, CKSUM (macro only), FINISH.
- IDLE: on in_valid, clear byte_count, overflow and the checksum; push the byte; go to STREAM. in_done is ignored.
- STREAM: push every in_valid byte. A rising edge of in_done (registered compare against the previous in_done) moves the FSM to DRAIN.
- DRAIN: pop only. An in_valid byte is dropped and sets overflow.
- Leaving DRAIN:
  - Without the macro: go to FINISH when the final entry is popped.
  - With the macro: go to CKSUM when the FIFO is empty.
- FINISH: frame_done=1 for one cycle, then IDLE.
- Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle. Otherwise the byte is dropped, overflow is set, and byte_count does not increment.
- byte_count increments once per accepted push and saturates at all-ones.
- out_valid = FIFO not empty (or the CKSUM state). Pop = out_valid & out_ready.
- out_data is the FIFO head (first-word fall-through from registered storage).
- out_last = 1 on the final popped entry in DRAIN (count==1) when the macro is off, or on the checksum byte when it is on.
- Pointers are log2(DEPTH)+1 bits: full when the MSBs differ and the LSBs are equal; empty when all bits are equal.
- clear: FIFO flushed, FSM to IDLE, overflow=0, byte_count=0, no frame_done.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, overflow=0, busy=0, frame_done=0, byte_count=0, FSM=IDLE, pointers=0.
- Push-to-output latency: a byte pushed in cycle N appears on out_valid/out_data in cycle N+1. There is no same-cycle bypass.
- Throughput: one byte per cycle in and out simultaneously.
- out_data and out_valid are held stable while out_valid & !out_ready.
- in_done edge to DRAIN: one cycle. A byte arriving in the same cycle as the edge is still accepted.
- frame_done is asserted the cycle after the out_last handshake.
- Asserting reset_n mid-frame: immediate return to reset values; no partial frame resumes.

## Configuration
- OUTPUT_SINK_CHECKSUM_EN defined:
  - After DRAIN empties, the CKSUM state presents one extra byte, the 8-bit modulo-256 sum of all accepted bytes, with out_valid=1 and out_last=1.
  - The FSM holds in CKSUM until out_ready, then goes to FINISH.
  - The checksum byte is not counted in byte_count.
- OUTPUT_SINK_CHECKSUM_EN undefined: no CKSUM state, no checksum register; out_last rides on the final data byte.

## Test plan
- Single word: 16 bytes 0x00..0x0F in consecutive cycles, out_ready=1, then in_done rises → 16 outputs in order starting 1 cycle after the first push. out_last is on 0x0F (macro off) or on checksum 0x78 (macro on). frame_done pulses once; byte_count=16; overflow=0.
- Backpressure: DEPTH=16, out_ready=0 while 20 bytes arrive → the first 16 are buffered, 4 are dropped, overflow=1, byte_count=16. Then out_ready=1 → exactly 16 bytes out, in order.
- Full with simultaneous pop: FIFO full, out_ready=1 and in_valid=1 in the same cycle → push accepted, no overflow.
- Byte during DRAIN: in_valid=1 one cycle after the in_done edge → byte dropped, overflow=1, byte_count unchanged.
- Mid-frame abort: after 8 bytes, pulse clear (or reset_n low) → out_valid=0 next cycle (immediately for reset), busy=0, byte_count=0, no frame_done. A new frame afterwards starts cleanly.
